// File: rtl/fp32_align_stage_pkg.sv
// Shared widths, stage-1 bundle and shift-amount helper for the FP32 add/sub alignment stage.
package fp32_addsub_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 24;
  localparam int GRS_W  = 3;
  localparam int ALN_W  = MAN_W + GRS_W;
  localparam int AMT_W  = 5;
  localparam int DIFF_W = EXP_W + 1;

  typedef struct packed {
    logic [EXP_W-1:0] exp_big;
    logic [MAN_W-1:0] man_big;
    logic [MAN_W-1:0] man_small;
    logic             sign_big;
    logic             eff_sub;
    logic             swap;
    logic [AMT_W-1:0] amt;
  } align_op_t;

  // Magnitude of the signed 9-bit exponent gap, clamped so a huge gap still flushes to sticky.
  function automatic logic [AMT_W-1:0] sat_shift_amt(input logic             exp_compare,
                                                     input logic [EXP_W-1:0] exp_diff);
    logic [DIFF_W-1:0] raw;
    logic [DIFF_W-1:0] mag;
    raw = {exp_compare, exp_diff};
    if (exp_compare) begin
      mag = ~raw + DIFF_W'(1);
    end else begin
      mag = raw;
    end
    if (mag > DIFF_W'(ALN_W)) begin
      return AMT_W'(ALN_W);
    end else begin
      return mag[AMT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/fp32_align_stage_if.sv
// Upstream (operand) and downstream (aligned result) valid/ready channels of the alignment stage.
interface fp32_align_in_if;
  import fp32_addsub_pkg::*;

  logic             i_valid;
  logic             o_ready;
  logic             i_sub;
  logic             i_sign_A;
  logic             i_sign_B;
  logic [EXP_W-1:0] i_exp_A;
  logic [EXP_W-1:0] i_exp_B;
  logic [MAN_W-1:0] i_man_A;
  logic [MAN_W-1:0] i_man_B;
  logic [EXP_W-1:0] i_exp_diff;
  logic             i_exp_compare;
  logic             i_same_exp;

  modport master (
    output i_valid, i_sub, i_sign_A, i_sign_B, i_exp_A, i_exp_B, i_man_A, i_man_B,
           i_exp_diff, i_exp_compare, i_same_exp,
    input  o_ready
  );

  modport slave (
    input  i_valid, i_sub, i_sign_A, i_sign_B, i_exp_A, i_exp_B, i_man_A, i_man_B,
           i_exp_diff, i_exp_compare, i_same_exp,
    output o_ready
  );
endinterface

interface fp32_align_out_if;
  import fp32_addsub_pkg::*;

  logic             o_valid;
  logic             i_ready;
  logic [EXP_W-1:0] o_exp_big;
  logic [ALN_W-1:0] o_man_big;
  logic [ALN_W-1:0] o_man_small;
  logic             o_sign_big;
  logic             o_eff_sub;
  logic             o_swap;

  modport master (
    output o_valid, o_exp_big, o_man_big, o_man_small, o_sign_big, o_eff_sub, o_swap,
    input  i_ready
  );

  modport slave (
    input  o_valid, o_exp_big, o_man_big, o_man_small, o_sign_big, o_eff_sub, o_swap,
    output i_ready
  );
endinterface

// File: rtl/fp32_align_stage_shifter.sv
// Combinational right barrel shifter; every bit pushed off the bottom is folded into the result LSB.
module align_shifter
  import fp32_addsub_pkg::*;
(
  input  logic [ALN_W-1:0] data_in,
  input  logic [AMT_W-1:0] amt,
  output logic [ALN_W-1:0] data_out
);

  logic [ALN_W-1:0] stage_s  [AMT_W+1];
  logic [AMT_W:0]   sticky_s;

  assign stage_s[0]  = data_in;
  assign sticky_s[0] = 1'b0;

  for (genvar k = 0; k < AMT_W; k++) begin : g_stage
    localparam int SH = 1 << k;
    localparam logic [ALN_W-1:0] LOST_MASK = ALN_W'((64'd1 << SH) - 64'd1);

    assign stage_s[k+1]  = amt[k] ? (stage_s[k] >> SH) : stage_s[k];
    assign sticky_s[k+1] = sticky_s[k] | (amt[k] & (|(stage_s[k] & LOST_MASK)));
  end

  assign data_out = {stage_s[AMT_W][ALN_W-1:1], stage_s[AMT_W][0] | sticky_s[AMT_W]};

endmodule

// File: rtl/fp32_align_stage.sv
// Two-deep valid/ready pipeline: stage 1 picks the larger operand and shift amount,
// stage 2 aligns the smaller mantissa with guard/round/sticky.
module fp32_align_stage
  import fp32_addsub_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst_n,
  fp32_align_in_if.slave   up,
  fp32_align_out_if.master dn
);

  align_op_t        s1_op_s;
  align_op_t        s1_op_r;
  logic             s1_v_r;
  logic             s2_v_r;
  logic             swap_s;
  logic             s1_advance_s;
  logic             ready_s;
  logic             accept_s;
  logic             load_s2_s;
  logic [ALN_W-1:0] small_aligned_s;

  logic [EXP_W-1:0] s2_exp_big_r;
  logic [ALN_W-1:0] s2_man_big_r;
  logic [ALN_W-1:0] s2_man_small_r;
  logic             s2_sign_big_r;
  logic             s2_eff_sub_r;
  logic             s2_swap_r;

  assign s1_advance_s = ~s2_v_r | dn.i_ready;
  assign ready_s      = ~s1_v_r | s1_advance_s;
  assign accept_s     = up.i_valid & ready_s;
  assign load_s2_s    = s1_v_r & s1_advance_s;
  assign up.o_ready   = ready_s;

  // Operand ordering: B wins on larger exponent, or on larger mantissa at equal exponent.
  always_comb begin
    s1_op_s = '0;
    swap_s  = up.i_exp_compare | (up.i_same_exp & (up.i_man_B > up.i_man_A));
    s1_op_s.swap    = swap_s;
    s1_op_s.amt     = sat_shift_amt(up.i_exp_compare, up.i_exp_diff);
    s1_op_s.eff_sub = up.i_sign_A ^ up.i_sign_B ^ up.i_sub;
    if (swap_s) begin
      s1_op_s.exp_big   = up.i_exp_B;
      s1_op_s.man_big   = up.i_man_B;
      s1_op_s.man_small = up.i_man_A;
      s1_op_s.sign_big  = up.i_sign_B ^ up.i_sub;
    end else begin
      s1_op_s.exp_big   = up.i_exp_A;
      s1_op_s.man_big   = up.i_man_A;
      s1_op_s.man_small = up.i_man_B;
      s1_op_s.sign_big  = up.i_sign_A;
    end
  end

  align_shifter u_shifter (
    .data_in  ({s1_op_r.man_small, {GRS_W{1'b0}}}),
    .amt      (s1_op_r.amt),
    .data_out (small_aligned_s)
  );

  // Stage 1 register bank.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1_v_r  <= 1'b0;
      s1_op_r <= '0;
    end else begin
      if (ready_s) begin
        s1_v_r <= up.i_valid;
      end
      if (accept_s) begin
        s1_op_r <= s1_op_s;
      end
    end
  end

  // Stage 2 register bank; holds its contents while the consumer stalls.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s2_v_r         <= 1'b0;
      s2_exp_big_r   <= '0;
      s2_man_big_r   <= '0;
      s2_man_small_r <= '0;
      s2_sign_big_r  <= 1'b0;
      s2_eff_sub_r   <= 1'b0;
      s2_swap_r      <= 1'b0;
    end else begin
      if (s1_advance_s) begin
        s2_v_r <= s1_v_r;
      end
      if (load_s2_s) begin
        s2_exp_big_r   <= s1_op_r.exp_big;
        s2_man_big_r   <= {s1_op_r.man_big, {GRS_W{1'b0}}};
        s2_man_small_r <= small_aligned_s;
        s2_sign_big_r  <= s1_op_r.sign_big;
        s2_eff_sub_r   <= s1_op_r.eff_sub;
        s2_swap_r      <= s1_op_r.swap;
      end
    end
  end

  assign dn.o_valid     = s2_v_r;
  assign dn.o_exp_big   = s2_exp_big_r;
  assign dn.o_man_big   = s2_man_big_r;
  assign dn.o_man_small = s2_man_small_r;
  assign dn.o_sign_big  = s2_sign_big_r;
  assign dn.o_eff_sub   = s2_eff_sub_r;
  assign dn.o_swap      = s2_swap_r;

endmodule

// File: tb/tb_fp32_align_stage.sv
// Directed self-checking bench for fp32_align_stage with hand-computed expected values.
module tb_fp32_align_stage;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  fp32_align_in_if  up_bus ();
  fp32_align_out_if dn_bus ();

  fp32_align_stage dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .up      (up_bus),
    .dn      (dn_bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Exponent difference/compare/same signals as exp_unit would produce them.
  task automatic drive_op(input logic sub, input logic sa, input logic sb,
                          input logic [7:0] ea, input logic [7:0] eb,
                          input logic [23:0] ma, input logic [23:0] mb);
    logic [8:0] d;
    d = {1'b0, ea} - {1'b0, eb};
    up_bus.i_sub         = sub;
    up_bus.i_sign_A      = sa;
    up_bus.i_sign_B      = sb;
    up_bus.i_exp_A       = ea;
    up_bus.i_exp_B       = eb;
    up_bus.i_man_A       = ma;
    up_bus.i_man_B       = mb;
    up_bus.i_exp_diff    = d[7:0];
    up_bus.i_exp_compare = d[8];
    up_bus.i_same_exp    = (ea == eb);
  endtask

  task automatic single(input string tag, input logic sub, input logic sa, input logic sb,
                        input logic [7:0] ea, input logic [7:0] eb,
                        input logic [23:0] ma, input logic [23:0] mb,
                        input logic [7:0] x_exp, input logic [26:0] x_big,
                        input logic [26:0] x_small, input logic x_sign,
                        input logic x_eff, input logic x_swap);
    @(negedge clk);
    drive_op(sub, sa, sb, ea, eb, ma, mb);
    up_bus.i_valid = 1'b1;
    dn_bus.i_ready = 1'b1;
    #1 check_eq({tag, "_ready"}, 32'(up_bus.o_ready), 32'd1);
    @(negedge clk);
    up_bus.i_valid = 1'b0;
    #1 check_eq({tag, "_lat1"}, 32'(dn_bus.o_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq({tag, "_valid"}, 32'(dn_bus.o_valid), 32'd1);
    check_eq({tag, "_exp"},   32'(dn_bus.o_exp_big), 32'(x_exp));
    check_eq({tag, "_big"},   32'(dn_bus.o_man_big), 32'(x_big));
    check_eq({tag, "_small"}, 32'(dn_bus.o_man_small), 32'(x_small));
    check_eq({tag, "_sign"},  32'(dn_bus.o_sign_big), 32'(x_sign));
    check_eq({tag, "_eff"},   32'(dn_bus.o_eff_sub), 32'(x_eff));
    check_eq({tag, "_swap"},  32'(dn_bus.o_swap), 32'(x_swap));
  endtask

  task automatic back_to_back();
    logic [26:0] exp_small [8];
    logic        rdy_pat   [4];
    logic [26:0] held_small;
    logic [7:0]  held_exp;
    logic        have_hold;
    logic        acc;
    logic        dlv;
    int          sent;
    int          got;
    int          cnt;
    exp_small = '{27'h4000000, 27'h3FFFFFC, 27'h1FFFFFE, 27'h0FFFFFF,
                  27'h07FFFFF, 27'h03FFFFF, 27'h01FFFFF, 27'h00FFFFF};
    rdy_pat   = '{1'b1, 1'b0, 1'b0, 1'b1};
    sent = 0; got = 0; cnt = 0; have_hold = 1'b0;
    held_small = '0; held_exp = '0;
    for (int c = 0; c < 80 && got < 8; c++) begin
      @(negedge clk);
      dn_bus.i_ready = rdy_pat[c % 4];
      if (sent < 8) begin
        drive_op(1'b0, 1'b0, 1'b0, 8'd120, 8'(120 - sent), 24'h800000, 24'hFFFFFF);
        up_bus.i_valid = 1'b1;
      end else begin
        up_bus.i_valid = 1'b0;
      end
      #1;
      check_eq("b2b_ready", 32'(up_bus.o_ready), 32'((cnt == 2 && !dn_bus.i_ready) ? 0 : 1));
      if (have_hold) begin
        check_eq("b2b_hold_valid", 32'(dn_bus.o_valid), 32'd1);
        check_eq("b2b_hold_small", 32'(dn_bus.o_man_small), 32'(held_small));
        check_eq("b2b_hold_exp",   32'(dn_bus.o_exp_big), 32'(held_exp));
      end
      if (dn_bus.o_valid && dn_bus.i_ready) begin
        check_eq("b2b_small", 32'(dn_bus.o_man_small), 32'(exp_small[got]));
        check_eq("b2b_swap",  32'(dn_bus.o_swap), 32'((got == 0) ? 1 : 0));
        check_eq("b2b_exp",   32'(dn_bus.o_exp_big), 32'd120);
      end
      have_hold  = dn_bus.o_valid && !dn_bus.i_ready;
      held_small = dn_bus.o_man_small;
      held_exp   = dn_bus.o_exp_big;
      acc = up_bus.i_valid && up_bus.o_ready;
      dlv = dn_bus.o_valid && dn_bus.i_ready;
      cnt = cnt + (acc ? 1 : 0) - (dlv ? 1 : 0);
      if (acc) sent++;
      if (dlv) got++;
    end
    check_eq("b2b_count", 32'(got), 32'd8);
    @(negedge clk);
    up_bus.i_valid = 1'b0;
    dn_bus.i_ready = 1'b1;
  endtask

  task automatic reset_mid_flight();
    @(negedge clk);
    dn_bus.i_ready = 1'b0;
    drive_op(1'b0, 1'b0, 1'b0, 8'd130, 8'd128, 24'h800000, 24'hC00001);
    up_bus.i_valid = 1'b1;
    @(negedge clk);
    drive_op(1'b1, 1'b0, 1'b0, 8'd100, 8'd100, 24'h900000, 24'hA00000);
    @(negedge clk);
    #1;
    check_eq("rst_pre_valid", 32'(dn_bus.o_valid), 32'd1);
    check_eq("rst_pre_ready", 32'(up_bus.o_ready), 32'd0);
    up_bus.i_valid = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_eq("rst_async_valid", 32'(dn_bus.o_valid), 32'd0);
    check_eq("rst_async_small", 32'(dn_bus.o_man_small), 32'd0);
    check_eq("rst_async_big",   32'(dn_bus.o_man_big), 32'd0);
    check_eq("rst_async_exp",   32'(dn_bus.o_exp_big), 32'd0);
    check_eq("rst_async_swap",  32'(dn_bus.o_swap), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    dn_bus.i_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check_eq("rst_no_spurious", 32'(dn_bus.o_valid), 32'd0);
    end
    single("post_rst", 1'b0, 1'b0, 1'b0, 8'd130, 8'd128, 24'h800000, 24'hC00001,
           8'd130, 27'h4000000, 27'h1800002, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_n = 1'b0;
    up_bus.i_valid = 1'b0;
    dn_bus.i_ready = 1'b1;
    drive_op(1'b0, 1'b0, 1'b0, 8'd0, 8'd0, 24'h0, 24'h0);
    #12;
    check_eq("reset_valid", 32'(dn_bus.o_valid), 32'd0);
    check_eq("reset_small", 32'(dn_bus.o_man_small), 32'd0);
    check_eq("reset_exp",   32'(dn_bus.o_exp_big), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check_eq("reset_ready", 32'(up_bus.o_ready), 32'd1);

    single("t1_add",    1'b0, 1'b0, 1'b0, 8'd130, 8'd128, 24'h800000, 24'hC00001,
           8'd130, 27'h4000000, 27'h1800002, 1'b0, 1'b0, 1'b0);
    single("t2_sat",    1'b0, 1'b0, 1'b1, 8'd0,   8'd255, 24'h000001, 24'h800000,
           8'd255, 27'h4000000, 27'h0000001, 1'b1, 1'b1, 1'b1);
    single("t3_samexp", 1'b1, 1'b0, 1'b0, 8'd100, 8'd100, 24'h900000, 24'hA00000,
           8'd100, 27'h5000000, 27'h4800000, 1'b1, 1'b1, 1'b1);
    single("tie",       1'b1, 1'b1, 1'b1, 8'd77,  8'd77,  24'hABCDEF, 24'hABCDEF,
           8'd77,  27'h55E6F78, 27'h55E6F78, 1'b1, 1'b1, 1'b0);
    single("amt3",      1'b0, 1'b0, 1'b0, 8'd103, 8'd100, 24'hC00000, 24'h800007,
           8'd103, 27'h6000000, 27'h0800007, 1'b0, 1'b0, 1'b0);
    single("amt6_stk",  1'b0, 1'b0, 1'b0, 8'd106, 8'd100, 24'hC00000, 24'h800007,
           8'd106, 27'h6000000, 27'h0100001, 1'b0, 1'b0, 1'b0);
    single("amt25",     1'b0, 1'b0, 1'b0, 8'd125, 8'd100, 24'hC00000, 24'h800000,
           8'd125, 27'h6000000, 27'h0000002, 1'b0, 1'b0, 1'b0);
    single("amt40_sat", 1'b0, 1'b0, 1'b0, 8'd140, 8'd100, 24'hC00000, 24'h800000,
           8'd140, 27'h6000000, 27'h0000001, 1'b0, 1'b0, 1'b0);
    single("zero_op",   1'b0, 1'b0, 1'b0, 8'd105, 8'd100, 24'h800000, 24'h000000,
           8'd105, 27'h4000000, 27'h0000000, 1'b0, 1'b0, 1'b0);

    back_to_back();
    reset_mid_flight();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
